h14tx_period_encoder: RTL and testbench
=======================================

# h14tx_period_encoder

Multi-channel TMDS period sequencer for the HDMI 1.4 transmit path. It sits between the video timing generator and the serialisers. It emits control symbols carrying sync and CTL bits, enforces a minimum control period, and inserts the 8-character video preamble and the 2-character video leading guard band. It then hands the lanes to upstream video symbols under a req/ready handshake. All lane outputs are registered.

## Interface
- NUM_CHANNELS, 3, number of TMDS lanes (≥3); lanes ≥3 behave as lane 2 except where stated
- PREAMBLE_LEN, 8, preamble length in characters (≥1)
- GUARD_LEN, 2, guard band length in characters (≥1)
- MIN_CTL_LEN, 4, minimum plain-control characters before a preamble may start (≥1)
- clk  in  1  pixel-rate clock
- rst_n  in  1  reset; asynchronous and active-low
- hsync  in  1  horizontal sync, lane 0 CTL bit 0
- vsync  in  1  vertical sync, lane 0 CTL bit 1
- ctl_ext  in  2×(NUM_CHANNELS-1)  CTL bits for lanes 1..N-1 during plain control
- vid_req  in  1  upstream requests a video period
- vid_ready  out  1  block is in VIDEO; lanes carry vid_symbols
- vid_symbols  in  10×NUM_CHANNELS  pre-encoded TMDS video characters, lane i at [10i+9:10i]
- symbol  out  10×NUM_CHANNELS  registered lane characters, same packing
- proto_err  out  1  sticky protocol error

## Operation
- CTL encoding, per lane, for ctl value {b1,b0}:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- Lane 0 always uses {vsync,hsync} in CTL, PRE and GUARD-abort cases.
- States and transitions:
  - CTL: lanes 1..N-1 encode ctl_ext. ctl_cnt increments, saturating at MIN_CTL_LEN. When vid_req=1 and ctl_cnt≥MIN_CTL_LEN, go to PRE with cnt=0.
  - PRE: lane 1 encodes 01 (CTL0=1, CTL1=0); lanes ≥2 encode 00. cnt counts PREAMBLE_LEN cycles, then the block goes to GUARD. If vid_req=0 in PRE, go to CTL with ctl_cnt=0; no error.
  - GUARD: lanes 0 and ≥2 carry 1011001100; lane 1 carries 0100110011. After GUARD_LEN cycles, go to VIDEO. If vid_req=0 in GUARD, go to CTL with ctl_cnt=0 and set proto_err.
  - VIDEO: vid_ready=1 and lanes carry vid_symbols. When vid_req=0, go to CTL with ctl_cnt=0. The cycle in which vid_req=0 is observed already outputs control characters.
- Counter width is $clog2(max(PREAMBLE_LEN, GUARD_LEN, MIN_CTL_LEN)+1). Counters never wrap.
- proto_err is cleared only by rst_n.

## Timing
- Reset values:
  - state CTL; ctl_cnt and cnt 0
  - vid_ready 0; proto_err 0
  - every symbol lane 1101010100
- vid_ready is a registered state decode and is high exactly while state=VIDEO.
- symbol latency is 1 cycle: symbol at edge N+1 reflects state and inputs sampled at edge N.
- With ctl_cnt already satisfied and vid_req rising at cycle 0:
  - PRE occupies cycles 0..PREAMBLE_LEN-1
  - GUARD occupies the next GUARD_LEN cycles
  - vid_ready rises at cycle PREAMBLE_LEN+GUARD_LEN (10 with defaults)
- Video data transfer occurs on each cycle with vid_req && vid_ready.
- Reset asserted mid-period forces reset values immediately (asynchronously). Sequencing restarts from CTL with ctl_cnt=0.

## Test plan
- Reset, idle: hold rst_n=0, then release with hsync=vsync=0 and ctl_ext=0 → every lane 1101010100, vid_ready=0, proto_err=0. Set hsync=1 → lane 0 becomes 0010101011 one cycle later.
- Minimum control: assert vid_req on the first cycle after reset → PRE starts only after 4 CTL cycles. Lane 1 shows 0010101011 and lane 2 shows 1101010100 for 8 cycles. Guard characters 1011001100 / 0100110011 / 1011001100 appear for 2 cycles. vid_ready rises 14 cycles after reset release.
- Video passthrough: in VIDEO, drive lane characters 0x155/0x2AA/0x0F0 → symbol equals them one cycle later. Drop vid_req → the next symbol is control and vid_ready=0.
- Preamble abort: drop vid_req on PRE cycle 3 → return to CTL with no proto_err. A new preamble requires 4 more CTL cycles.
- Guard violation: drop vid_req in the first GUARD cycle → CTL next cycle and proto_err=1. proto_err stays 1 through subsequent video periods until reset.
- Parametrised: NUM_CHANNELS=4, PREAMBLE_LEN=4, GUARD_LEN=3 → lane 3 is 1101010100 in PRE and 1011001100 in GUARD. vid_ready rises 7 cycles after PRE entry.

Source files
------------

// File: rtl/h14tx_period_encoder_if.sv
// Lane-side bundle between the video timing generator / upstream video source
// and the HDMI 1.4 TMDS period sequencer.
interface h14tx_period_encoder_if #(
  parameter int NUM_CHANNELS = 3
);
  logic                          hsync;
  logic                          vsync;
  logic [2*(NUM_CHANNELS-1)-1:0] ctl_ext;
  logic                          vid_req;
  logic                          vid_ready;
  logic [10*NUM_CHANNELS-1:0]    vid_symbols;
  logic [10*NUM_CHANNELS-1:0]    symbol;
  logic                          proto_err;

  modport master (
    output hsync, vsync, ctl_ext, vid_req, vid_symbols,
    input  vid_ready, symbol, proto_err
  );

  modport slave (
    input  hsync, vsync, ctl_ext, vid_req, vid_symbols,
    output vid_ready, symbol, proto_err
  );
endinterface

// File: rtl/h14tx_period_encoder.sv
// HDMI 1.4 TMDS period sequencer: control periods, video preamble, leading
// guard band and video passthrough, with registered lane characters.
module h14tx_period_encoder #(
  parameter int NUM_CHANNELS = 3,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int MIN_CTL_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  h14tx_period_encoder_if.slave bus
);

  localparam int MAX_PG  = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int MAX_LEN = (MAX_PG > MIN_CTL_LEN) ? MAX_PG : MIN_CTL_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] MIN_CTL    = CW'(MIN_CTL_LEN);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_LEN - 1);

  localparam logic [9:0] CTL_00  = 10'b1101010100;
  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  typedef enum logic [1:0] {
    ST_CTL,
    ST_PRE,
    ST_GUARD,
    ST_VIDEO
  } state_e;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    logic [9:0] code;
    case (c)
      2'b00: code = 10'b1101010100;
      2'b01: code = 10'b0010101011;
      2'b10: code = 10'b0101010100;
      2'b11: code = 10'b1010101011;
    endcase
    return code;
  endfunction

  state_e                     state_q, state_d;
  logic [CW-1:0]              ctl_cnt_q, ctl_cnt_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              ctl_cnt_inc;
  logic                       vid_ready_q, vid_ready_d;
  logic                       proto_err_q, proto_err_d;
  logic [10*NUM_CHANNELS-1:0] symbol_q, symbol_d;
  logic [10*NUM_CHANNELS-1:0] ctl_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CTL;
      ctl_cnt_q   <= '0;
      cnt_q       <= '0;
      vid_ready_q <= 1'b0;
      proto_err_q <= 1'b0;
      symbol_q    <= {NUM_CHANNELS{CTL_00}};
    end else begin
      state_q     <= state_d;
      ctl_cnt_q   <= ctl_cnt_d;
      cnt_q       <= cnt_d;
      vid_ready_q <= vid_ready_d;
      proto_err_q <= proto_err_d;
      symbol_q    <= symbol_d;
    end
  end

  // The CTL cycle in progress already counts toward the minimum control period.
  always_comb begin
    state_d     = state_q;
    ctl_cnt_d   = ctl_cnt_q;
    cnt_d       = cnt_q;
    ctl_cnt_inc = (ctl_cnt_q >= MIN_CTL) ? ctl_cnt_q : ctl_cnt_q + 1'b1;
    case (state_q)
      ST_CTL: begin
        ctl_cnt_d = ctl_cnt_inc;
        if (bus.vid_req && (ctl_cnt_inc >= MIN_CTL)) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (!bus.vid_req) begin
          state_d   = ST_CTL;
          ctl_cnt_d = '0;
          cnt_d     = '0;
        end else if (cnt_q == PRE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (!bus.vid_req) begin
          state_d   = ST_CTL;
          ctl_cnt_d = '0;
          cnt_d     = '0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = ST_VIDEO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_VIDEO: begin
        if (!bus.vid_req) begin
          state_d   = ST_CTL;
          ctl_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CTL;
        ctl_cnt_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  always_comb begin
    ctl_word       = '0;
    ctl_word[9:0]  = ctl_code({bus.vsync, bus.hsync});
    for (int i = 1; i < NUM_CHANNELS; i++) begin
      ctl_word[10*i +: 10] = ctl_code(bus.ctl_ext[2*(i-1) +: 2]);
    end
  end

  // Any period dropped by vid_req falls straight back to plain control characters.
  always_comb begin
    symbol_d    = ctl_word;
    vid_ready_d = (state_d == ST_VIDEO);
    proto_err_d = proto_err_q | ((state_q == ST_GUARD) && !bus.vid_req);
    if (bus.vid_req) begin
      case (state_q)
        ST_PRE: begin
          for (int i = 1; i < NUM_CHANNELS; i++) begin
            symbol_d[10*i +: 10] = (i == 1) ? ctl_code(2'b01) : ctl_code(2'b00);
          end
        end
        ST_GUARD: begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            symbol_d[10*i +: 10] = (i == 1) ? GUARD_B : GUARD_A;
          end
        end
        ST_VIDEO: symbol_d = bus.vid_symbols;
        default:  symbol_d = ctl_word;
      endcase
    end
  end

  assign bus.symbol    = symbol_q;
  assign bus.vid_ready = vid_ready_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_h14tx_period_encoder.sv
// Directed scoreboard bench for h14tx_period_encoder: default 3-lane instance
// plus a 4-lane instance with a short preamble and a longer guard band.
module tb_h14tx_period_encoder;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GA  = 10'b1011001100;
  localparam logic [9:0] GB  = 10'b0100110011;

  localparam logic [39:0] MASK_A  = 40'h003FFFFFFF;
  localparam logic [39:0] MASK_L0 = 40'h00000003FF;
  localparam logic [39:0] MASK_B  = 40'hFFFFFFFFFF;

  typedef struct {
    string       tag;
    bit          dut_b;
    logic [39:0] sym;
    logic [39:0] mask;
    logic        rdy;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  h14tx_period_encoder_if #(.NUM_CHANNELS(3)) bus_a ();
  h14tx_period_encoder_if #(.NUM_CHANNELS(4)) bus_b ();

  h14tx_period_encoder #(
    .NUM_CHANNELS(3), .PREAMBLE_LEN(8), .GUARD_LEN(2), .MIN_CTL_LEN(4)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  h14tx_period_encoder #(
    .NUM_CHANNELS(4), .PREAMBLE_LEN(4), .GUARD_LEN(3), .MIN_CTL_LEN(4)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  function automatic logic [39:0] a3(input logic [9:0] l0, input logic [9:0] l1,
                                     input logic [9:0] l2);
    return {10'b0, l2, l1, l0};
  endfunction

  function automatic logic [39:0] b4(input logic [9:0] l0, input logic [9:0] l1,
                                     input logic [9:0] l2, input logic [9:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push_exp(input string tag, input bit dut_b, input logic [39:0] sym,
                          input logic [39:0] mask, input logic rdy, input logic err);
    exp_t e;
    e.tag = tag; e.dut_b = dut_b; e.sym = sym; e.mask = mask; e.rdy = rdy; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [39:0] obs_sym;
    logic        obs_rdy;
    logic        obs_err;
    total_cnt++;
    assert (sb_q.size() != 0) pass_cnt++;
    else $error("[TB] FAIL scoreboard_empty: got 0 entries expected at least 1");
    if (sb_q.size() != 0) begin
      e       = sb_q.pop_front();
      obs_sym = e.dut_b ? bus_b.symbol : {10'b0, bus_a.symbol};
      obs_rdy = e.dut_b ? bus_b.vid_ready : bus_a.vid_ready;
      obs_err = e.dut_b ? bus_b.proto_err : bus_a.proto_err;
      total_cnt++;
      assert ((obs_sym & e.mask) === (e.sym & e.mask)) pass_cnt++;
      else $error("[TB] FAIL %s symbol: got %h expected %h", e.tag, obs_sym & e.mask,
                  e.sym & e.mask);
      total_cnt++;
      assert (obs_rdy === e.rdy) pass_cnt++;
      else $error("[TB] FAIL %s vid_ready: got %b expected %b", e.tag, obs_rdy, e.rdy);
      total_cnt++;
      assert (obs_err === e.err) pass_cnt++;
      else $error("[TB] FAIL %s proto_err: got %b expected %b", e.tag, obs_err, e.err);
    end
  endtask

  // Inputs are already driven; the expectation is for the character registered
  // at the coming clock edge.
  task automatic apply_stimulus(input string tag, input bit dut_b, input logic [39:0] sym,
                                input logic [39:0] mask, input logic rdy, input logic err);
    push_exp(tag, dut_b, sym, mask, rdy, err);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic run_n(input int n, input string tag, input bit dut_b,
                       input logic [39:0] sym, input logic [39:0] mask,
                       input logic rdy, input logic err);
    for (int k = 0; k < n; k++) apply_stimulus(tag, dut_b, sym, mask, rdy, err);
  endtask

  // Asserts reset away from a clock edge, checks the asynchronous clear, then
  // releases it one cycle later.
  task automatic reset_cycle();
    rst_n         = 1'b0;
    bus_a.vid_req = 1'b0;
    bus_b.vid_req = 1'b0;
    #1;
    push_exp("reset_a", 1'b0, a3(C00, C00, C00), MASK_A, 1'b0, 1'b0);
    check_output();
    push_exp("reset_b", 1'b1, b4(C00, C00, C00, C00), MASK_B, 1'b0, 1'b0);
    check_output();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n             = 1'b1;
    bus_a.hsync       = 1'b0;
    bus_a.vsync       = 1'b0;
    bus_a.ctl_ext     = '0;
    bus_a.vid_req     = 1'b0;
    bus_a.vid_symbols = '0;
    bus_b.hsync       = 1'b0;
    bus_b.vsync       = 1'b0;
    bus_b.ctl_ext     = '0;
    bus_b.vid_req     = 1'b0;
    bus_b.vid_symbols = '0;
    #2;
    reset_cycle();

    // Idle control and CTL encoding on every lane
    apply_stimulus("idle", 1'b0, a3(C00, C00, C00), MASK_A, 1'b0, 1'b0);
    bus_a.hsync = 1'b1;
    apply_stimulus("hsync", 1'b0, a3(C01, C00, C00), MASK_A, 1'b0, 1'b0);
    bus_a.hsync = 1'b0;
    bus_a.vsync = 1'b1;
    apply_stimulus("vsync", 1'b0, a3(C10, C00, C00), MASK_A, 1'b0, 1'b0);
    bus_a.hsync   = 1'b1;
    bus_a.ctl_ext = {2'b11, 2'b01};
    apply_stimulus("ctl_ext", 1'b0, a3(C11, C01, C11), MASK_A, 1'b0, 1'b0);

    // Request right after reset: 4 CTL, 8 PRE, 2 GUARD, ready at edge 14
    reset_cycle();
    bus_a.hsync   = 1'b1;
    bus_a.vsync   = 1'b0;
    bus_a.ctl_ext = {2'b10, 2'b11};
    bus_a.vid_req = 1'b1;
    run_n(4, "min_ctl", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b0);
    run_n(8, "preamble", 1'b0, a3(C01, C01, C00), MASK_A, 1'b0, 1'b0);
    apply_stimulus("guard0", 1'b0, a3(GA, GB, GA), MASK_A, 1'b0, 1'b0);
    apply_stimulus("guard1", 1'b0, a3(GA, GB, GA), MASK_A, 1'b1, 1'b0);

    // Video passthrough and exit
    bus_a.vid_symbols = {10'h0F0, 10'h2AA, 10'h155};
    apply_stimulus("video0", 1'b0, a3(10'h155, 10'h2AA, 10'h0F0), MASK_A, 1'b1, 1'b0);
    bus_a.vid_symbols = {10'h1C7, 10'h000, 10'h3FF};
    apply_stimulus("video1", 1'b0, a3(10'h3FF, 10'h000, 10'h1C7), MASK_A, 1'b1, 1'b0);
    bus_a.vid_req = 1'b0;
    apply_stimulus("video_exit", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b0);

    // Preamble abort on PRE cycle 3, then a full minimum control period again
    bus_a.vid_req = 1'b1;
    run_n(4, "ctl_before_pre", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b0);
    run_n(3, "pre_partial", 1'b0, a3(C01, C01, C00), MASK_A, 1'b0, 1'b0);
    bus_a.vid_req = 1'b0;
    apply_stimulus("pre_abort", 1'b0, a3(C01, C00, C00), MASK_L0, 1'b0, 1'b0);
    bus_a.vid_req = 1'b1;
    run_n(4, "ctl_after_abort", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b0);
    run_n(8, "pre_again", 1'b0, a3(C01, C01, C00), MASK_A, 1'b0, 1'b0);

    // Guard violation sets the sticky error
    bus_a.vid_req = 1'b0;
    apply_stimulus("guard_abort", 1'b0, a3(C01, C00, C00), MASK_L0, 1'b0, 1'b1);
    bus_a.vid_req = 1'b1;
    run_n(4, "ctl_after_err", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b1);
    run_n(8, "pre_after_err", 1'b0, a3(C01, C01, C00), MASK_A, 1'b0, 1'b1);
    apply_stimulus("guard0_err", 1'b0, a3(GA, GB, GA), MASK_A, 1'b0, 1'b1);
    apply_stimulus("guard1_err", 1'b0, a3(GA, GB, GA), MASK_A, 1'b1, 1'b1);
    bus_a.vid_symbols = {10'h2AA, 10'h155, 10'h0F0};
    apply_stimulus("video_err", 1'b0, a3(10'h0F0, 10'h155, 10'h2AA), MASK_A, 1'b1, 1'b1);
    bus_a.vid_req = 1'b0;
    apply_stimulus("exit_err", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b1);
    bus_a.vid_req = 1'b1;
    run_n(4, "ctl_sticky", 1'b0, a3(C01, C11, C10), MASK_A, 1'b0, 1'b1);
    run_n(2, "pre_sticky", 1'b0, a3(C01, C01, C00), MASK_A, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a preamble clears everything
    reset_cycle();

    // Four lanes, PREAMBLE_LEN=4, GUARD_LEN=3
    bus_b.ctl_ext = {2'b11, 2'b00, 2'b00};
    bus_b.vid_req = 1'b1;
    run_n(4, "b_ctl", 1'b1, b4(C00, C00, C00, C11), MASK_B, 1'b0, 1'b0);
    run_n(4, "b_preamble", 1'b1, b4(C00, C01, C00, C00), MASK_B, 1'b0, 1'b0);
    run_n(2, "b_guard", 1'b1, b4(GA, GB, GA, GA), MASK_B, 1'b0, 1'b0);
    apply_stimulus("b_guard_last", 1'b1, b4(GA, GB, GA, GA), MASK_B, 1'b1, 1'b0);
    bus_b.vid_symbols = {10'h3C3, 10'h0F0, 10'h2AA, 10'h155};
    apply_stimulus("b_video", 1'b1, b4(10'h155, 10'h2AA, 10'h0F0, 10'h3C3), MASK_B,
                   1'b1, 1'b0);
    bus_b.vid_req = 1'b0;
    apply_stimulus("b_exit", 1'b1, b4(C00, C00, C00, C11), MASK_B, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
